missile_pool: RTL and testbench

Multi-shot successor to the single-missile mover. It manages a pool of `NUM_MISSILES` independent missile slots for one tank. Fire requests are accepted on a key edge, subject to a frame-based cooldown and slot availability. Each slot advances in 1/2^`FRAC_BITS` sub-pixel fixed point once per frame and retires on collision or on leaving the screen. It sits between the keyboard/tank logic and the per-missile drawing and collision objects.

---
 rtl/missile_pkg.sv | 37 +++
 rtl/missile_slot.sv | 106 ++++++++++
 rtl/missile_pool.sv | 99 +++++++++
 tb/tb_missile_pool.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/missile_pkg.sv
// Shared types for the missile pool: travel direction, slot state and the
// direction-to-axis-sign helper used by every slot.
package missile_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } step_t;

    // Unit step on each axis for a direction; screen Y grows downward.
    function automatic step_t dir_step(dir_t d);
        step_t s;
        s.dx = 2'sd0;
        s.dy = 2'sd0;
        case (d)
            UP:      s.dy = -2'sd1;
            RIGHT:   s.dx = 2'sd1;
            DOWN:    s.dy = 2'sd1;
            LEFT:    s.dx = -2'sd1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/missile_slot.sv
// One missile slot: IDLE/FLYING state, signed sub-pixel accumulators and the
// off-screen check. Collision beats movement; IDLE slots hold zero position.
module missile_slot
    import missile_pkg::*;
#(
    parameter int COORD_W   = 11,
    parameter int FRAC_BITS = 6,
    parameter int SPEED     = 300,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
)
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_load,
    input  logic               i_sof,
    input  logic               i_collision,
    input  logic [COORD_W-1:0] i_launch_x,
    input  logic [COORD_W-1:0] i_launch_y,
    input  dir_t               i_dir,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_draw_en,
    output dir_t               o_dir,
    output slot_state_t        o_state
);

    localparam int ACC_W = COORD_W + FRAC_BITS + 1;
    localparam logic signed [ACC_W-1:0] STEP  = ACC_W'(SPEED);
    localparam logic signed [ACC_W-1:0] MAX_X = ACC_W'(SCREEN_W - 1);
    localparam logic signed [ACC_W-1:0] MAX_Y = ACC_W'(SCREEN_H - 1);

    slot_state_t             r_state, w_state_next;
    logic signed [ACC_W-1:0] r_x, r_y, w_x_next, w_y_next;
    logic signed [ACC_W-1:0] w_mx, w_my, w_mx_int, w_my_int;
    dir_t                    r_dir, w_dir_next;
    step_t                   w_step;
    logic                    w_off;

    // Candidate position after one frame, and whether it leaves the screen.
    always_comb begin
        w_step = dir_step(r_dir);
        w_mx   = r_x;
        w_my   = r_y;
        if (w_step.dx == 2'sd1)       w_mx = r_x + STEP;
        else if (w_step.dx == -2'sd1) w_mx = r_x - STEP;
        if (w_step.dy == 2'sd1)       w_my = r_y + STEP;
        else if (w_step.dy == -2'sd1) w_my = r_y - STEP;
        w_mx_int = w_mx >>> FRAC_BITS;
        w_my_int = w_my >>> FRAC_BITS;
        w_off    = w_mx[ACC_W-1] || w_my[ACC_W-1] ||
                   (w_mx_int > MAX_X) || (w_my_int > MAX_Y);
    end

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_dir_next   = r_dir;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_next = FLYING;
                    w_x_next     = '0;
                    w_y_next     = '0;
                    w_x_next[FRAC_BITS +: COORD_W] = i_launch_x;
                    w_y_next[FRAC_BITS +: COORD_W] = i_launch_y;
                    w_dir_next   = i_dir;
                end
            end
            FLYING: begin
                if (i_collision || (i_sof && w_off)) begin
                    w_state_next = IDLE;
                    w_x_next     = '0;
                    w_y_next     = '0;
                end else if (i_sof) begin
                    w_x_next = w_mx;
                    w_y_next = w_my;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_dir   <= UP;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_dir   <= w_dir_next;
        end
    end

    // Accumulators are cleared on retire, so the integer slice is 0 when IDLE.
    assign o_x       = r_x[FRAC_BITS +: COORD_W];
    assign o_y       = r_y[FRAC_BITS +: COORD_W];
    assign o_draw_en = (r_state == FLYING);
    assign o_dir     = r_dir;
    assign o_state   = r_state;

endmodule

// File: rtl/missile_pool.sv
// Pool of missile slots for one tank: fire-key edge detection, frame cooldown,
// lowest-free-slot allocation and the flying-slot count.
module missile_pool
    import missile_pkg::*;
#(
    parameter int NUM_MISSILES    = 4,
    parameter int COORD_W         = 11,
    parameter int FRAC_BITS       = 6,
    parameter int SPEED           = 300,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480
)
(
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   startOfFrame,
    input  logic                                   fireKey,
    input  logic [COORD_W-1:0]                     tankTopLeftX,
    input  logic [COORD_W-1:0]                     tankTopLeftY,
    input  logic [1:0]                             tankDir,
    input  logic [NUM_MISSILES-1:0]                collision,
    output logic [NUM_MISSILES-1:0][COORD_W-1:0]   topLeftX,
    output logic [NUM_MISSILES-1:0][COORD_W-1:0]   topLeftY,
    output logic [NUM_MISSILES-1:0]                drawEn,
    output logic [NUM_MISSILES-1:0][1:0]           dir,
    output logic                                   fired,
    output logic [$clog2(NUM_MISSILES+1)-1:0]      activeCount
);

    localparam int CNT_W = $clog2(NUM_MISSILES + 1);
    localparam int CD_W  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    logic                    r_key_prev;
    logic [CD_W-1:0]         r_cooldown;
    logic                    r_fired;
    logic                    w_edge, w_accept;
    logic [NUM_MISSILES-1:0] w_idle, w_alloc, w_load;
    slot_state_t             w_state [NUM_MISSILES];
    dir_t                    w_dir   [NUM_MISSILES];

    assign w_edge   = fireKey && !r_key_prev;
    assign w_accept = w_edge && (r_cooldown == '0) && (|w_idle);
    // x & -x isolates the lowest set bit: the lowest-index IDLE slot.
    assign w_alloc  = w_idle & (~w_idle + NUM_MISSILES'(1));
    assign w_load   = w_accept ? w_alloc : '0;

    for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
        missile_slot #(
            .COORD_W   (COORD_W),
            .FRAC_BITS (FRAC_BITS),
            .SPEED     (SPEED),
            .SCREEN_W  (SCREEN_W),
            .SCREEN_H  (SCREEN_H)
        ) u_slot (
            .clk         (clk),
            .resetN      (resetN),
            .i_load      (w_load[g]),
            .i_sof       (startOfFrame),
            .i_collision (collision[g]),
            .i_launch_x  (tankTopLeftX),
            .i_launch_y  (tankTopLeftY),
            .i_dir       (dir_t'(tankDir)),
            .o_x         (topLeftX[g]),
            .o_y         (topLeftY[g]),
            .o_draw_en   (drawEn[g]),
            .o_dir       (w_dir[g]),
            .o_state     (w_state[g])
        );
        assign w_idle[g] = (w_state[g] == IDLE);
        assign dir[g]    = w_dir[g];
    end

    // Previous key resets high so a key held through reset never fires.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_key_prev <= 1'b1;
            r_cooldown <= '0;
            r_fired    <= 1'b0;
        end else begin
            r_key_prev <= fireKey;
            r_fired    <= w_accept;
            if (w_accept)
                r_cooldown <= CD_LOAD;
            else if (startOfFrame && (r_cooldown != '0))
                r_cooldown <= r_cooldown - CD_W'(1);
        end
    end

    always_comb begin
        activeCount = '0;
        for (int i = 0; i < NUM_MISSILES; i++)
            activeCount = activeCount + CNT_W'(drawEn[i]);
    end

    assign fired = r_fired;

endmodule

// File: tb/tb_missile_pool.sv
// Bench for missile_pool: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a pixel-level behavioural model.
module tb_missile_pool;

    localparam int N   = 4;
    localparam int CW  = 11;
    localparam int FB  = 6;
    localparam int SPD = 300;
    localparam int CDF = 8;
    localparam int SW  = 640;
    localparam int SH  = 480;
    localparam int ONE = 1 << FB;

    logic                  clk = 1'b0;
    logic                  resetN = 1'b0;
    logic                  startOfFrame = 1'b0;
    logic                  fireKey = 1'b1;
    logic [CW-1:0]         tankTopLeftX = '0;
    logic [CW-1:0]         tankTopLeftY = '0;
    logic [1:0]            tankDir = 2'b00;
    logic [N-1:0]          collision = '0;
    logic [N-1:0][CW-1:0]  topLeftX, topLeftY;
    logic [N-1:0]          drawEn;
    logic [N-1:0][1:0]     dir;
    logic                  fired;
    logic [2:0]            activeCount;

    missile_pool #(
        .NUM_MISSILES    (N),
        .COORD_W         (CW),
        .FRAC_BITS       (FB),
        .SPEED           (SPD),
        .COOLDOWN_FRAMES (CDF),
        .SCREEN_W        (SW),
        .SCREEN_H        (SH)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .fireKey      (fireKey),
        .tankTopLeftX (tankTopLeftX),
        .tankTopLeftY (tankTopLeftY),
        .tankDir      (tankDir),
        .collision    (collision),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .drawEn       (drawEn),
        .dir          (dir),
        .fired        (fired),
        .activeCount  (activeCount)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    // ---------------- behavioural model (pixel * 64 integers) ----------------
    bit m_fly [N];
    int m_x   [N];
    int m_y   [N];
    int m_dir [N];
    int m_cd;
    bit m_prev;
    bit m_fired;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_fly[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
        end
        m_cd = 0; m_prev = 1; m_fired = 0;
    endtask

    task automatic model_step();
        bit fire_edge;
        int slot;
        int nx, ny;
        fire_edge = fireKey && !m_prev;
        m_prev    = fireKey;
        slot = -1;
        for (int i = 0; i < N; i++)
            if (!m_fly[i] && slot < 0) slot = i;
        m_fired = fire_edge && (m_cd == 0) && (slot >= 0);
        for (int i = 0; i < N; i++) begin
            if (m_fly[i]) begin
                if (collision[i]) begin
                    m_fly[i] = 0;
                end else if (startOfFrame) begin
                    nx = m_x[i]; ny = m_y[i];
                    case (m_dir[i])
                        0: ny -= SPD;
                        1: nx += SPD;
                        2: ny += SPD;
                        default: nx -= SPD;
                    endcase
                    if (nx < 0 || ny < 0 || nx >= SW * ONE || ny >= SH * ONE) m_fly[i] = 0;
                    else begin m_x[i] = nx; m_y[i] = ny; end
                end
            end
        end
        if (m_fired) begin
            m_fly[slot] = 1;
            m_x[slot]   = int'(tankTopLeftX) * ONE;
            m_y[slot]   = int'(tankTopLeftY) * ONE;
            m_dir[slot] = int'(tankDir);
        end
        if (m_fired) m_cd = CDF;
        else if (startOfFrame && m_cd > 0) m_cd--;
    endtask

    always @(posedge clk or negedge resetN) begin
        if (!resetN) model_reset();
        else model_step();
    end

    // Single compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < N; i++) begin
                cnt += int'(m_fly[i]);
                check($sformatf("model_x%0d", i), topLeftX[i], m_fly[i] ? m_x[i] / ONE : 0);
                check($sformatf("model_y%0d", i), topLeftY[i], m_fly[i] ? m_y[i] / ONE : 0);
                check($sformatf("model_draw%0d", i), drawEn[i], m_fly[i]);
                check($sformatf("model_dir%0d", i), dir[i], m_dir[i]);
            end
            check("model_fired", fired, m_fired);
            check("model_count", activeCount, cnt);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit sof, input bit key, input logic [N-1:0] col);
        startOfFrame = sof;
        fireKey      = key;
        collision    = col;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) step(1'b1, 1'b1, '0);
    endtask

    task automatic shoot(input int x, input int y, input int d);
        tankTopLeftX = CW'(x);
        tankTopLeftY = CW'(y);
        tankDir      = 2'(d);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int shots;
        bit key;
        logic [N-1:0] col;

        resetN = 1'b0;
        fireKey = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_draw", drawEn, 0);
        check("reset_count", activeCount, 0);
        check("reset_fired", fired, 0);
        check("reset_x0", topLeftX[0], 0);

        // Key held across reset release: no shot.
        resetN = 1'b1;
        shots = 0;
        repeat (100) begin
            step(1'b0, 1'b1, '0);
            shots += int'(fired);
        end
        check("held_key_shots", shots, 0);
        check("held_key_draw", drawEn, 0);

        // Launch right from (100,200).
        shoot(100, 200, 1);
        check("launch_x", topLeftX[0], 100);
        check("launch_y", topLeftY[0], 200);
        check("launch_draw", drawEn, 4'b0001);
        check("launch_fired", fired, 1);
        step(1'b0, 1'b1, '0);
        check("fired_one_cycle", fired, 0);
        frames(1);
        check("right_1frame_x", topLeftX[0], 104);
        frames(1);
        check("right_2frame_x", topLeftX[0], 109);
        check("right_2frame_y", topLeftY[0], 200);

        // Collision on the frame cycle: retire without moving.
        step(1'b1, 1'b1, 4'b0001);
        check("coll_sof_draw", drawEn, 4'b0000);
        check("coll_sof_x", topLeftX[0], 0);
        step(1'b0, 1'b1, 4'b0001);
        check("coll_idle_draw", drawEn, 4'b0000);
        frames(5);

        // Upward from Y=10: 10 -> 5 -> 0 -> retired.
        shoot(50, 10, 0);
        check("up_launch_y", topLeftY[0], 10);
        frames(1);
        check("up_1frame_y", topLeftY[0], 5);
        frames(1);
        check("up_2frame_y", topLeftY[0], 0);
        frames(1);
        check("up_retire_draw", drawEn[0], 0);
        check("up_retire_count", activeCount, 0);
        frames(5);

        // Cooldown: rejected at 3 and 7 frames, accepted at 8 into slot1.
        shoot(200, 100, 1);
        check("cd_first_fired", fired, 1);
        frames(3);
        shoot(200, 100, 1);
        check("cd_3frame_fired", fired, 0);
        check("cd_3frame_draw", drawEn, 4'b0001);
        frames(4);
        shoot(200, 100, 1);
        check("cd_7frame_fired", fired, 0);
        frames(1);
        shoot(300, 150, 2);
        check("cd_8frame_fired", fired, 1);
        check("cd_8frame_draw", drawEn, 4'b0011);
        check("slot1_dir", dir[1], 2);
        check("slot1_y", topLeftY[1], 150);

        // Fill the pool, reject when full, refill the freed slot2.
        frames(8);
        shoot(20, 300, 1);
        frames(8);
        shoot(20, 400, 1);
        check("full_draw", drawEn, 4'b1111);
        check("full_count", activeCount, 4);
        frames(8);
        shoot(30, 30, 1);
        check("full_reject_fired", fired, 0);
        check("full_reject_draw", drawEn, 4'b1111);
        step(1'b0, 1'b1, 4'b0100);
        check("free_slot2_draw", drawEn, 4'b1011);
        check("free_slot2_count", activeCount, 3);
        shoot(60, 60, 3);
        check("refill_fired", fired, 1);
        check("refill_draw", drawEn, 4'b1111);
        check("refill_x2", topLeftX[2], 60);
        check("refill_dir2", dir[2], 3);

        // Asynchronous reset mid-flight.
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_draw", drawEn, 0);
        check("async_rst_count", activeCount, 0);
        check("async_rst_x0", topLeftX[0], 0);
        check("async_rst_dir2", dir[2], 0);
        @(negedge clk);
        resetN = 1'b1;

        // Randomized run against the model.
        key = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 2) == 0) key = !key;
            if (!key) begin
                tankTopLeftX = CW'($urandom_range(0, 700));
                tankTopLeftY = CW'($urandom_range(0, 520));
                tankDir      = 2'($urandom_range(0, 3));
            end
            for (int i = 0; i < N; i++) col[i] = ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 4) == 0, key, col);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
